// File: rtl/sram_1kx1_ctrl.sv
// Request/ack sequencer for a bank of WIDTH 1Kx1 SRAM parts; write latency 2+WE_CYCLES (+RD_CYCLES with verify), read RD_CYCLES.
// Backpressure: busy from acceptance through ack; req is only sampled in IDLE, one request in flight.
// Optional write-verify readback is compiled in with `define SRAM_CTRL_VERIFY_EN.
module sram_1kx1_ctrl #(
  parameter int WIDTH     = 32,
  parameter int WE_CYCLES = 2,
  parameter int RD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req,
  input  logic             wr,
  input  logic [9:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  output logic             ack,
  output logic             busy,
  output logic [WIDTH-1:0] rdata,
  output logic [9:0]       ram_a,
  output logic             ram_ce_n,
  output logic             ram_we_n,
  output logic [WIDTH-1:0] ram_di,
  input  logic [WIDTH-1:0] ram_do,
  output logic             verify_err
);

  localparam logic [3:0] WE_LOAD = 4'(WE_CYCLES - 1);
  localparam logic [3:0] RD_LOAD = 4'(RD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_WPULSE = 3'd2,
    S_WHOLD  = 3'd3,
    S_VWAIT  = 3'd4,
    S_RWAIT  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [9:0]       ram_a_q, ram_a_d;
  logic [WIDTH-1:0] ram_di_q, ram_di_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             ram_ce_n_q, ram_ce_n_d;
  logic             ram_we_n_q, ram_we_n_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; cnt counts down the remaining cycles of a timed state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (wr) begin
            state_d = S_SETUP;
          end else begin
            state_d = S_RWAIT;
            cnt_d   = RD_LOAD;
          end
        end
      end
      S_SETUP: begin
        state_d = S_WPULSE;
        cnt_d   = WE_LOAD;
      end
      S_WPULSE: begin
        if (cnt_q == 4'd0) state_d = S_WHOLD;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_WHOLD: begin
`ifdef SRAM_CTRL_VERIFY_EN
        state_d = S_VWAIT;
        cnt_d   = RD_LOAD;
`else
        state_d = S_DONE;
`endif
      end
`ifdef SRAM_CTRL_VERIFY_EN
      S_VWAIT: begin
        if (cnt_q == 4'd0) state_d = S_DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
`endif
      S_RWAIT: begin
        if (cnt_q == 4'd0) state_d = S_DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they change on the same edge as the state
  always_comb begin
    ram_ce_n_d = 1'b1;
    ram_we_n_d = 1'b1;
    ack_d      = 1'b0;
    busy_d     = 1'b1;
    case (state_d)
      S_IDLE:   busy_d     = 1'b0;
      S_SETUP:  ram_ce_n_d = 1'b0;
      S_WPULSE: begin
        ram_ce_n_d = 1'b0;
        ram_we_n_d = 1'b0;
      end
      S_WHOLD:  ram_ce_n_d = 1'b0;
      S_VWAIT:  ram_ce_n_d = 1'b0;
      S_RWAIT:  ram_ce_n_d = 1'b0;
      S_DONE:   ack_d      = 1'b1;
      default:  busy_d     = 1'b0;
    endcase
  end

  // Address and write data change only on acceptance, never inside a WE pulse
  always_comb begin
    ram_a_d  = ram_a_q;
    ram_di_d = ram_di_q;
    rdata_d  = rdata_q;
    if (state_q == S_IDLE && req) begin
      ram_a_d  = addr;
      ram_di_d = wdata;
    end
    if (state_q == S_RWAIT && cnt_q == 4'd0) begin
      rdata_d = ram_do;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_a_q    <= 10'd0;
      ram_di_q   <= '0;
      rdata_q    <= '0;
      ram_ce_n_q <= 1'b1;
      ram_we_n_q <= 1'b1;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      ram_a_q    <= ram_a_d;
      ram_di_q   <= ram_di_d;
      rdata_q    <= rdata_d;
      ram_ce_n_q <= ram_ce_n_d;
      ram_we_n_q <= ram_we_n_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
    end
  end

`ifdef SRAM_CTRL_VERIFY_EN
  logic verify_err_q, verify_err_d;

  // Sticky until reset; readback is compared against the data just written
  always_comb begin
    verify_err_d = verify_err_q;
    if (state_q == S_VWAIT && cnt_q == 4'd0 && ram_do != ram_di_q) begin
      verify_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) verify_err_q <= 1'b0;
    else          verify_err_q <= verify_err_d;
  end

  assign verify_err = verify_err_q;
`else
  assign verify_err = 1'b0;
`endif

  assign ack      = ack_q;
  assign busy     = busy_q;
  assign rdata    = rdata_q;
  assign ram_a    = ram_a_q;
  assign ram_ce_n = ram_ce_n_q;
  assign ram_we_n = ram_we_n_q;
  assign ram_di   = ram_di_q;

endmodule

// File: tb/tb_sram_1kx1_ctrl.sv
// Bench for sram_1kx1_ctrl: directed vector table plus hand-written busy-toggle, mid-write reset and verify sequences.
// RAM model writes on any clock with CE_N and WE_N low; optional bit-3 stuck-at-0 when SRAM_CTRL_VERIFY_EN is defined.
module tb_sram_1kx1_ctrl;

  localparam int WIDTH     = 32;
  localparam int WE_CYCLES = 2;
  localparam int RD_CYCLES = 2;
`ifdef SRAM_CTRL_VERIFY_EN
  localparam logic [31:0] MASK   = 32'hFFFF_FFF7;
  localparam int          WR_LAT = 2 + WE_CYCLES + RD_CYCLES;
  localparam logic [31:0] EXP_VE = 32'd1;
`else
  localparam logic [31:0] MASK   = 32'hFFFF_FFFF;
  localparam int          WR_LAT = 2 + WE_CYCLES;
  localparam logic [31:0] EXP_VE = 32'd0;
`endif
  localparam int RD_LAT = RD_CYCLES;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             req = 1'b0;
  logic             wr = 1'b0;
  logic [9:0]       addr = '0;
  logic [WIDTH-1:0] wdata = '0;
  logic             ack, busy, ram_ce_n, ram_we_n, verify_err;
  logic [WIDTH-1:0] rdata, ram_di, ram_do;
  logic [9:0]       ram_a;

  logic [WIDTH-1:0] mem [1024];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sram_1kx1_ctrl #(.WIDTH(WIDTH), .WE_CYCLES(WE_CYCLES), .RD_CYCLES(RD_CYCLES)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .ack(ack), .busy(busy), .rdata(rdata), .ram_a(ram_a), .ram_ce_n(ram_ce_n),
    .ram_we_n(ram_we_n), .ram_di(ram_di), .ram_do(ram_do), .verify_err(verify_err)
  );

  always @(posedge clk) begin
    if (!ram_ce_n && !ram_we_n) mem[ram_a] <= ram_di;
  end
  assign ram_do = ram_ce_n ? '0 : (mem[ram_a] & MASK);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Caller is at a negedge; returns at the negedge after the post-ack IDLE cycle
  task automatic do_req(input logic w, input logic [9:0] a, input logic [31:0] d,
                        output int lat, output int we_lo, output int viol, output logic [31:0] rd);
    req = 1'b1; wr = w; addr = a; wdata = d;
    lat = -1; we_lo = 0; viol = 0;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req = 1'b0;
        if (!busy || ram_ce_n || ram_a != a) viol++;
        if (w && ram_di != d) viol++;
      end
      if (!ram_we_n) begin
        we_lo++;
        if (ram_ce_n || ram_a != a) viol++;
      end
      if (ack) lat = k - 1;
    end
    rd = rdata;
    @(negedge clk);
    if (busy || ack || !ram_ce_n || !ram_we_n) viol++;
  endtask

  typedef struct {
    logic        w;
    logic [9:0]  a;
    logic [31:0] d;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t        vec [8];
  int          lat, we_lo, viol, acks, bad;
  logic [31:0] rd, hold;
  logic        saw_wp;

  initial begin
    vec[0] = '{1'b1, 10'h3FF, 32'hA5A5_5A5A, 32'h0};
    vec[1] = '{1'b0, 10'h3FF, 32'h0,         32'hA5A5_5A5A};
    vec[2] = '{1'b1, 10'h000, 32'hFFFF_FFFF, 32'h0};
    vec[3] = '{1'b1, 10'h001, 32'h0000_0000, 32'h0};
    vec[4] = '{1'b0, 10'h000, 32'h0,         32'hFFFF_FFFF};
    vec[5] = '{1'b0, 10'h001, 32'h0,         32'h0000_0000};
    vec[6] = '{1'b1, 10'h200, 32'h1234_5678, 32'h0};
    vec[7] = '{1'b0, 10'h3FF, 32'h0,         32'hA5A5_5A5A};

    for (int i = 0; i < 1024; i++) mem[i] = '0;

    #12;
    chk("rst_ce_n",  {31'd0, ram_ce_n},   32'd1);
    chk("rst_we_n",  {31'd0, ram_we_n},   32'd1);
    chk("rst_ack",   {31'd0, ack},        32'd0);
    chk("rst_busy",  {31'd0, busy},       32'd0);
    chk("rst_rdata", rdata,               32'd0);
    chk("rst_ram_a", {22'd0, ram_a},      32'd0);
    chk("rst_ram_di", ram_di,             32'd0);
    chk("rst_verr",  {31'd0, verify_err}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    hold = 32'h0;
    for (int i = 0; i < 8; i++) begin
      do_req(vec[i].w, vec[i].a, vec[i].d, lat, we_lo, viol, rd);
      if (!vec[i].w) hold = vec[i].exp_rd & MASK;
      chk($sformatf("v%0d_lat", i),   lat,   vec[i].w ? WR_LAT : RD_LAT);
      chk($sformatf("v%0d_we_lo", i), we_lo, vec[i].w ? WE_CYCLES : 0);
      chk($sformatf("v%0d_viol", i),  viol,  0);
      chk($sformatf("v%0d_rdata", i), rd,    hold);
    end

    // Inputs toggled while busy must not disturb the accepted write
    req = 1'b1; wr = 1'b1; addr = 10'h155; wdata = 32'h0F0F_1234;
    acks = 0; bad = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ram_a != 10'h155 || ram_di != 32'h0F0F_1234) bad++;
      if (ack) begin
        acks++;
        req = 1'b0;
      end else if (acks == 0) begin
        addr = 10'($urandom);
        wr = 1'($urandom);
        wdata = $urandom;
      end
    end
    chk("tog_acks", acks, 1);
    chk("tog_latched", bad, 0);
    do_req(1'b0, 10'h155, 32'h0, lat, we_lo, viol, rd);
    chk("tog_rd", rd, 32'h0F0F_1234 & MASK);

    // Asynchronous reset in the middle of a WE pulse
    req = 1'b1; wr = 1'b1; addr = 10'h2AA; wdata = 32'hDEAD_BEEF;
    saw_wp = 1'b0;
    for (int k = 1; k <= 10 && !saw_wp; k++) begin
      @(negedge clk);
      req = 1'b0;
      if (!ram_we_n) saw_wp = 1'b1;
    end
    chk("arst_in_wpulse", {31'd0, saw_wp}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_we_n", {31'd0, ram_we_n}, 32'd1);
    chk("arst_ce_n", {31'd0, ram_ce_n}, 32'd1);
    chk("arst_busy", {31'd0, busy},     32'd0);
    chk("arst_rdata", rdata,            32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    acks = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    chk("arst_no_ack", acks, 0);
    do_req(1'b1, 10'h2AA, 32'h1357_9BDF, lat, we_lo, viol, rd);
    chk("post_rst_wlat", lat, WR_LAT);
    do_req(1'b0, 10'h2AA, 32'h0, lat, we_lo, viol, rd);
    chk("post_rst_rd", rd, 32'h1357_9BDF & MASK);
    chk("post_rst_rlat", lat, RD_LAT);

    // Bit 3 set in the write data exposes the stuck bit when verify is built in
    do_req(1'b1, 10'h008, 32'hFFFF_FFFF, lat, we_lo, viol, rd);
    chk("verr_after_wr", {31'd0, verify_err}, EXP_VE);
    do_req(1'b1, 10'h009, 32'h0000_0000, lat, we_lo, viol, rd);
    chk("verr_sticky", {31'd0, verify_err}, EXP_VE);
    chk("verr_wlat", lat, WR_LAT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
